// File: rtl/cap_tag_seq.sv
// Capability-tag cache sequencer: one tag op in flight, held until the
// cache hits, then settled, sampled and returned over a response handshake.
module cap_tag_seq #(
  parameter int WID    = 64,
  parameter int SETTLE = 2,
  parameter int TMO    = 1023
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           op_valid,
  output logic           op_ready,
  input  logic [1:0]     op_cmd,
  input  logic [31:0]    op_adr,
  input  logic           op_tag,
  input  logic [3:0]     op_id,
  output logic           rsp_valid,
  input  logic           rsp_ready,
  output logic [3:0]     rsp_id,
  output logic           rsp_tag,
  output logic [WID-1:0] rsp_tags,
  output logic           rsp_err,
  output logic           c_wr,
  output logic           c_wr_cap,
  output logic           c_load_tags,
  output logic           c_tagi,
  output logic [31:0]    c_adr,
  input  logic           c_hit,
  input  logic           c_tago,
  input  logic [WID-1:0] c_tagso
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_SETTLE,
    S_RESP
  } state_t;

  localparam logic [9:0] SET_LAST = 10'(SETTLE - 1);
  localparam logic [9:0] TMO_CNT  = 10'(TMO);

  state_t     state;
  logic [9:0] cnt;
  logic [1:0] cmd;
  logic [3:0] id;
  logic       qual_hit;

  assign op_ready = (state == S_IDLE) && !rst;

  // c_hit in the first ISSUE cycle still reflects the previous address
  assign qual_hit = c_hit && (cnt != 10'd0);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      cnt         <= '0;
      cmd         <= '0;
      id          <= '0;
      rsp_valid   <= 1'b0;
      rsp_id      <= '0;
      rsp_tag     <= 1'b0;
      rsp_tags    <= '0;
      rsp_err     <= 1'b0;
      c_wr        <= 1'b0;
      c_wr_cap    <= 1'b0;
      c_load_tags <= 1'b0;
      c_tagi      <= 1'b0;
      c_adr       <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (op_valid && op_ready) begin
            cmd         <= op_cmd;
            id          <= op_id;
            c_adr       <= op_adr;
            cnt         <= '0;
            c_wr        <= (op_cmd == 2'd1);
            c_wr_cap    <= (op_cmd == 2'd2);
            c_tagi      <= (op_cmd == 2'd2) && op_tag;
            c_load_tags <= (op_cmd == 2'd3);
            state       <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          cnt <= cnt + 10'd1;
          if (qual_hit) begin
            c_wr        <= 1'b0;
            c_wr_cap    <= 1'b0;
            c_load_tags <= 1'b0;
            c_tagi      <= 1'b0;
            cnt         <= '0;
            state       <= S_SETTLE;
          end else if (cnt == TMO_CNT) begin
            c_wr        <= 1'b0;
            c_wr_cap    <= 1'b0;
            c_load_tags <= 1'b0;
            c_tagi      <= 1'b0;
            rsp_err     <= 1'b1;
            rsp_tag     <= 1'b0;
            rsp_tags    <= '0;
            rsp_id      <= id;
            rsp_valid   <= 1'b1;
            state       <= S_RESP;
          end
        end
        S_SETTLE: begin
          cnt <= cnt + 10'd1;
          // c_adr stays put so the cache outputs are stable when sampled
          if (cnt == SET_LAST) begin
            rsp_tag   <= (cmd == 2'd0) ? c_tago : 1'b0;
            rsp_tags  <= (cmd == 2'd3) ? c_tagso : '0;
            rsp_err   <= 1'b0;
            rsp_id    <= id;
            rsp_valid <= 1'b1;
            state     <= S_RESP;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_cap_tag_seq.sv
// Directed bench for cap_tag_seq: reset, each command, miss latency,
// timeout and response backpressure.
module tb_cap_tag_seq;

  localparam int WID = 64;

  logic           clk;
  logic           rst;
  logic           op_valid;
  logic           op_ready;
  logic [1:0]     op_cmd;
  logic [31:0]    op_adr;
  logic           op_tag;
  logic [3:0]     op_id;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [3:0]     rsp_id;
  logic           rsp_tag;
  logic [WID-1:0] rsp_tags;
  logic           rsp_err;
  logic           c_wr;
  logic           c_wr_cap;
  logic           c_load_tags;
  logic           c_tagi;
  logic [31:0]    c_adr;
  logic           c_hit;
  logic           c_tago;
  logic [WID-1:0] c_tagso;

  int checks;
  int errors;

  cap_tag_seq #(.WID(WID), .SETTLE(2), .TMO(1023)) dut (
    .clk(clk),
    .rst(rst),
    .op_valid(op_valid),
    .op_ready(op_ready),
    .op_cmd(op_cmd),
    .op_adr(op_adr),
    .op_tag(op_tag),
    .op_id(op_id),
    .rsp_valid(rsp_valid),
    .rsp_ready(rsp_ready),
    .rsp_id(rsp_id),
    .rsp_tag(rsp_tag),
    .rsp_tags(rsp_tags),
    .rsp_err(rsp_err),
    .c_wr(c_wr),
    .c_wr_cap(c_wr_cap),
    .c_load_tags(c_load_tags),
    .c_tagi(c_tagi),
    .c_adr(c_adr),
    .c_hit(c_hit),
    .c_tago(c_tago),
    .c_tagso(c_tagso)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [1:0] cmd, input logic [31:0] adr,
                       input logic tag, input logic [3:0] id);
    op_valid = 1'b1;
    op_cmd   = cmd;
    op_adr   = adr;
    op_tag   = tag;
    op_id    = id;
  endtask

  task automatic test_reset();
    logic [3:0] strb;
    rst = 1'b1;
    #1;
    checks++;
    if (op_ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_op_ready: got %b want 0", op_ready);
    end
    tick();
    tick();
    strb = {c_wr, c_wr_cap, c_load_tags, c_tagi};
    checks++;
    if (strb !== 4'b0 || rsp_valid !== 1'b0 || c_adr !== 32'h0) begin
      errors++;
      $display("FAIL rst_outputs: got strb=%b rv=%b adr=%h want 0",
               strb, rsp_valid, c_adr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_release_ready: got %b want 1", op_ready);
    end
    // reset asserted in the middle of a WRITE cap
    offer(2'd2, 32'h2000_0400, 1'b1, 4'd3);
    tick();
    op_valid = 1'b0;
    checks++;
    if (c_wr_cap !== 1'b1 || c_adr !== 32'h2000_0400) begin
      errors++;
      $display("FAIL mid_issue_strobe: got wr_cap=%b adr=%h want 1 20000400",
               c_wr_cap, c_adr);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (c_wr_cap !== 1'b0 || c_tagi !== 1'b0 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL mid_issue_reset: got wr_cap=%b tagi=%b rdy=%b want 0 0 0",
               c_wr_cap, c_tagi, op_ready);
    end
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (op_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got rdy=%b rv=%b want 1 0",
               op_ready, rsp_valid);
    end
  endtask

  task automatic test_write_cap();
    rsp_ready = 1'b1;
    c_hit = 1'b0;
    offer(2'd2, 32'h2000_0408, 1'b1, 4'd5);
    tick();
    op_valid = 1'b0;
    checks++;
    if (c_wr_cap !== 1'b1 || c_tagi !== 1'b1 || c_wr !== 1'b0 ||
        op_ready !== 1'b0) begin
      errors++;
      $display("FAIL wcap_c1: got wr_cap=%b tagi=%b wr=%b rdy=%b want 1 1 0 0",
               c_wr_cap, c_tagi, c_wr, op_ready);
    end
    tick();
    c_hit = 1'b1;
    checks++;
    if (c_wr_cap !== 1'b1 || c_tagi !== 1'b1 ||
        c_adr !== 32'h2000_0408) begin
      errors++;
      $display("FAIL wcap_c2: got wr_cap=%b tagi=%b adr=%h want 1 1 20000408",
               c_wr_cap, c_tagi, c_adr);
    end
    tick();
    c_hit = 1'b0;
    checks++;
    if (c_wr_cap !== 1'b0 || c_tagi !== 1'b0 || rsp_valid !== 1'b0 ||
        c_adr !== 32'h2000_0408) begin
      errors++;
      $display("FAIL wcap_c3: got wr_cap=%b tagi=%b rv=%b adr=%h want 0 0 0 20000408",
               c_wr_cap, c_tagi, rsp_valid, c_adr);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wcap_c4: got rv=%b want 0", rsp_valid);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 4'd5 || rsp_tag !== 1'b0 ||
        rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL wcap_rsp: got rv=%b id=%h tag=%b err=%b want 1 5 0 0",
               rsp_valid, rsp_id, rsp_tag, rsp_err);
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL wcap_c6: got rv=%b rdy=%b want 0 1", rsp_valid, op_ready);
    end
  endtask

  task automatic test_read_miss();
    int bad;
    bad = 0;
    c_hit = 1'b0;
    c_tago = 1'b0;
    offer(2'd0, 32'h2000_0408, 1'b0, 4'd7);
    tick();
    op_valid = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (c_adr !== 32'h2000_0408 || c_wr !== 1'b0 || c_wr_cap !== 1'b0 ||
          c_load_tags !== 1'b0 || rsp_valid !== 1'b0)
        bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL read_miss_hold: got %0d bad cycles want 0", bad);
    end
    c_hit = 1'b1;
    tick();
    c_hit = 1'b0;
    c_tago = 1'b1;
    tick();
    checks++;
    if (c_adr !== 32'h2000_0408 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL read_settle: got adr=%h rv=%b want 20000408 0",
               c_adr, rsp_valid);
    end
    tick();
    c_tago = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tag !== 1'b1 || rsp_err !== 1'b0 ||
        rsp_id !== 4'd7 || rsp_tags !== '0) begin
      errors++;
      $display("FAIL read_rsp: got rv=%b tag=%b err=%b id=%h tags=%h want 1 1 0 7 0",
               rsp_valid, rsp_tag, rsp_err, rsp_id, rsp_tags);
    end
    tick();
  endtask

  task automatic test_load_tags();
    c_hit = 1'b0;
    offer(2'd3, 32'h2000_1000, 1'b0, 4'd9);
    tick();
    op_valid = 1'b0;
    checks++;
    if (c_load_tags !== 1'b1 || c_wr !== 1'b0 || c_adr !== 32'h2000_1000) begin
      errors++;
      $display("FAIL ltags_strobe: got lt=%b wr=%b adr=%h want 1 0 20001000",
               c_load_tags, c_wr, c_adr);
    end
    tick();
    c_hit = 1'b1;
    tick();
    c_hit = 1'b0;
    c_tago = 1'b1;
    c_tagso = 64'hDEAD_BEEF_0123_4567;
    checks++;
    if (c_load_tags !== 1'b0) begin
      errors++;
      $display("FAIL ltags_drop: got lt=%b want 0", c_load_tags);
    end
    tick();
    tick();
    c_tagso = '0;
    c_tago = 1'b0;
    checks++;
    if (rsp_valid !== 1'b1 || rsp_tags !== 64'hDEAD_BEEF_0123_4567 ||
        rsp_tag !== 1'b0 || rsp_id !== 4'd9) begin
      errors++;
      $display("FAIL ltags_rsp: got rv=%b tags=%h tag=%b id=%h want 1 deadbeef01234567 0 9",
               rsp_valid, rsp_tags, rsp_tag, rsp_id);
    end
    tick();
  endtask

  task automatic test_timeout();
    offer(2'd1, 32'h2000_0500, 1'b0, 4'hA);
    tick();
    op_valid = 1'b0;
    c_hit = 1'b1;
    tick();
    c_hit = 1'b0;
    checks++;
    if (c_wr !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_unqualified: got wr=%b rv=%b want 1 0",
               c_wr, rsp_valid);
    end
    // ISSUE covers cycles 1..1024 (cnt 0..1023); now in cycle 2
    for (int i = 0; i < 1022; i++) tick();
    checks++;
    if (c_wr !== 1'b1 || rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL tmo_last_issue: got wr=%b rv=%b want 1 0",
               c_wr, rsp_valid);
    end
    rsp_ready = 1'b0;
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_err !== 1'b1 || c_wr !== 1'b0 ||
        rsp_id !== 4'hA || rsp_tag !== 1'b0 || rsp_tags !== '0) begin
      errors++;
      $display("FAIL tmo_rsp: got rv=%b err=%b wr=%b id=%h tag=%b want 1 1 0 a 0",
               rsp_valid, rsp_err, c_wr, rsp_id, rsp_tag);
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || c_wr !== 1'b0) begin
      errors++;
      $display("FAIL tmo_after: got rv=%b wr=%b want 0 0", rsp_valid, c_wr);
    end
  endtask

  task automatic test_back_to_back();
    int bad;
    bad = 0;
    rsp_ready = 1'b0;
    c_tago = 1'b1;
    offer(2'd0, 32'h2000_0600, 1'b0, 4'd1);
    tick();
    op_valid = 1'b0;
    tick();
    c_hit = 1'b1;
    tick();
    c_hit = 1'b0;
    tick();
    tick();
    c_tago = 1'b0;
    offer(2'd0, 32'h2000_0700, 1'b0, 4'd2);
    for (int i = 0; i < 10; i++) begin
      if (op_ready !== 1'b0 || rsp_valid !== 1'b1 || rsp_id !== 4'd1 ||
          rsp_tag !== 1'b1 || rsp_err !== 1'b0 || c_adr !== 32'h2000_0600)
        bad++;
      tick();
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL bp_stable: got %0d bad cycles want 0", bad);
    end
    rsp_ready = 1'b1;
    tick();
    checks++;
    if (rsp_valid !== 1'b0 || op_ready !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: got rv=%b rdy=%b want 0 1",
               rsp_valid, op_ready);
    end
    tick();
    op_valid = 1'b0;
    checks++;
    if (c_adr !== 32'h2000_0700 || op_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_next_accept: got adr=%h rdy=%b want 20000700 0",
               c_adr, op_ready);
    end
    tick();
    c_hit = 1'b1;
    tick();
    c_hit = 1'b0;
    tick();
    tick();
    checks++;
    if (rsp_valid !== 1'b1 || rsp_id !== 4'd2 || rsp_tag !== 1'b0) begin
      errors++;
      $display("FAIL bp_second_rsp: got rv=%b id=%h tag=%b want 1 2 0",
               rsp_valid, rsp_id, rsp_tag);
    end
    tick();
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    op_valid  = 1'b0;
    op_cmd    = 2'd0;
    op_adr    = 32'h0;
    op_tag    = 1'b0;
    op_id     = 4'd0;
    rsp_ready = 1'b1;
    c_hit     = 1'b0;
    c_tago    = 1'b0;
    c_tagso   = '0;
    test_reset();
    test_write_cap();
    test_read_miss();
    test_load_tags();
    test_timeout();
    test_back_to_back();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
